// File: rtl/sd_sector_stream.sv
// Multi-sector read sequencer with a 2x512-byte ping-pong buffer between the SPI sector reader
// and a ready/valid byte stream, so stream stalls never back-pressure the card.
module sd_sector_stream #(
  parameter logic [3:0] CARD_IDLE    = 4'd8,
  parameter logic [3:0] CARD_READING = 4'd9
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_start,
  input  logic [31:0] cmd_first_sector,
  input  logic [15:0] cmd_num_sectors,
  output logic        busy,
  output logic        done,
  output logic        rd_start,
  output logic [31:0] rd_sector_no,
  input  logic        rd_done,
  input  logic [3:0]  rd_card_stat,
  input  logic        rd_rvalid,
  input  logic [8:0]  rd_raddr,
  input  logic [7:0]  rd_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last
);

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_FILL} wstate_e;

  wstate_e     wstate;
  logic [31:0] next_sector;
  logic [15:0] remaining;
  logic [15:0] drain_left;
  logic        wsel;
  logic        rsel;
  logic [1:0]  full;
  logic [8:0]  rd_idx;
  logic        issued_all;
  logic        out_end;
  logic [7:0]  bank_mem [1024];

  logic        cmd_accept;
  logic        mem_we;
  logic        fill_done;
  logic        advance;
  logic        issue;
  logic        hs_end;

  always_comb begin
    cmd_accept = cmd_start && !busy;
    mem_we     = (wstate == W_FILL) && rd_rvalid;
    fill_done  = (wstate == W_FILL) && rd_done;
    advance    = !out_valid || out_ready;
    issue      = advance && full[rsel] && !issued_all;
    hs_end     = out_valid && out_ready && out_end;
  end

  // Bank storage: one write port from the reader, one read port into the output register.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      bank_mem[{wsel, rd_raddr}] <= rd_rdata;
    end
  end

  // Write side: request one sector at a time and capture it into bank[wsel].
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wstate       <= W_IDLE;
      rd_start     <= 1'b0;
      rd_sector_no <= 32'd0;
      next_sector  <= 32'd0;
      remaining    <= 16'd0;
      wsel         <= 1'b0;
    end else begin
      if (cmd_accept) begin
        next_sector <= cmd_first_sector;
        remaining   <= cmd_num_sectors;
      end
      unique case (wstate)
        W_IDLE: begin
          if (busy && (remaining != 16'd0) && !full[wsel] && (rd_card_stat == CARD_IDLE)) begin
            wstate       <= W_REQ;
            rd_start     <= 1'b1;
            rd_sector_no <= next_sector;
          end
        end
        W_REQ: begin
          if (rd_card_stat == CARD_READING) begin
            rd_start <= 1'b0;
            wstate   <= W_FILL;
          end
        end
        W_FILL: begin
          if (rd_done) begin
            wsel        <= ~wsel;
            next_sector <= next_sector + 32'd1;
            remaining   <= remaining - 16'd1;
            wstate      <= W_IDLE;
          end
        end
        default: wstate <= W_IDLE;
      endcase
    end
  end

  // Bank-full flags: set by the writer, cleared by the reader; never the same bank in one cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      full <= 2'b00;
    end else begin
      if (fill_done) begin
        full[wsel] <= 1'b1;
      end
      if (hs_end) begin
        full[rsel] <= 1'b0;
      end
    end
  end

  // Read side: the output register doubles as the RAM read register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      drain_left <= 16'd0;
      rsel       <= 1'b0;
      rd_idx     <= 9'd0;
      issued_all <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= 8'd0;
      out_last   <= 1'b0;
      out_end    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (cmd_accept) begin
        drain_left <= cmd_num_sectors;
        if (cmd_num_sectors == 16'd0) begin
          done <= 1'b1;
        end else begin
          busy <= 1'b1;
        end
      end

      if (advance) begin
        out_valid <= issue;
        if (issue) begin
          out_data <= bank_mem[{rsel, rd_idx}];
          out_end  <= (rd_idx == 9'd511);
          out_last <= (rd_idx == 9'd511) && (drain_left == 16'd1);
          rd_idx   <= rd_idx + 9'd1;
          if (rd_idx == 9'd511) begin
            issued_all <= 1'b1;
          end
        end else begin
          out_end  <= 1'b0;
          out_last <= 1'b0;
        end
      end

      if (hs_end) begin
        rsel       <= ~rsel;
        issued_all <= 1'b0;
        drain_left <= drain_left - 16'd1;
        if (drain_left == 16'd1) begin
          done <= 1'b1;
          busy <= 1'b0;
        end
      end
    end
  end

endmodule
